// File: rtl/pwm_duty_capture.sv
// PWM duty/period capture: synchronizes ampPWM, measures high time and
// period between rising edges, and flags stuck-high / stuck-low levels.
module pwm_duty_capture #(
  parameter int               WIDTH   = 11,
  parameter logic [WIDTH-1:0] PERIOD  = 11'd1042,
  parameter int               TIMEOUT = 2084
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ampPWM,
  input  logic             ampSD,
  output logic [WIDTH-1:0] duty_count,
  output logic [WIDTH:0]   period_count,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic             period_err
);

  localparam int            CW       = WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state;
  state_t        state_next;
  logic          sync1;
  logic          sync2;
  logic          hist;
  logic          rise;
  logic          fall;
  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] lo_cnt;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] hi_inc;
  logic [CW-1:0] lo_inc;
  logic [CW:0]   sum;
  logic [CW-1:0] period_sat;
  logic [WIDTH-1:0] duty_sat;
  logic          publish;
  logic          to_hi;
  logic          to_lo;
  logic          idle_to;

  // Two-flop synchronizer, history flop, and registered edge pulses.
  // hist is the level that lines up with the rise/fall pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= ampPWM;
      sync2 <= sync1;
      hist  <= sync2;
      rise  <= sync2 & ~hist;
      fall  <= ~sync2 & hist;
    end
  end

  // Saturating increments and the published values derived from them.
  // lo_inc includes the current LOW cycle, which closes the period.
  always_comb begin
    hi_inc     = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + 1'b1;
    lo_inc     = (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + 1'b1;
    sum        = {1'b0, hi_cnt} + {1'b0, lo_inc};
    period_sat = sum[CW] ? CNT_MAX : sum[CW-1:0];
    duty_sat   = hi_cnt[CW-1] ? DUTY_MAX : hi_cnt[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and event decode; an edge always beats a timeout.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    to_hi      = 1'b0;
    to_lo      = 1'b0;
    idle_to    = 1'b0;
    if (!ampSD) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) state_next = HIGH;
          else if (!fall && idle_cnt == TO_LAST) idle_to = 1'b1;
        end
        HIGH: begin
          if (fall) begin
            state_next = LOW;
          end else if (hi_cnt == TO_LAST) begin
            to_hi      = 1'b1;
            state_next = IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            publish    = 1'b1;
            state_next = HIGH;
          end else if (lo_cnt == TO_LAST) begin
            to_lo      = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Phase counters; both clear on every entry to HIGH and on leaving to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_cnt   <= '0;
      lo_cnt   <= '0;
      idle_cnt <= '0;
    end else if (!ampSD) begin
      hi_cnt   <= '0;
      lo_cnt   <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          hi_cnt <= '0;
          lo_cnt <= '0;
          if (rise || fall)          idle_cnt <= '0;
          else if (idle_cnt != TO_LAST) idle_cnt <= idle_cnt + 1'b1;
        end
        HIGH: begin
          idle_cnt <= '0;
          if (state_next == IDLE) hi_cnt <= '0;
          else                    hi_cnt <= hi_inc;
        end
        LOW: begin
          idle_cnt <= '0;
          if (rise || state_next == IDLE) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
          end else begin
            lo_cnt <= lo_inc;
          end
        end
        default: begin
          hi_cnt   <= '0;
          lo_cnt   <= '0;
          idle_cnt <= '0;
        end
      endcase
    end
  end

  // Published results and status flags; measurements hold while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_count   <= '0;
      period_count <= '0;
      valid        <= 1'b0;
      stuck_hi     <= 1'b0;
      stuck_lo     <= 1'b0;
      period_err   <= 1'b0;
    end else if (!ampSD) begin
      valid    <= 1'b0;
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise || fall) begin
        stuck_hi <= 1'b0;
        stuck_lo <= 1'b0;
      end
      if (publish) begin
        duty_count   <= duty_sat;
        period_count <= period_sat;
        period_err   <= (sum != {2'b00, PERIOD});
        valid        <= 1'b1;
      end
      if (to_hi) begin
        duty_count   <= PERIOD;
        period_count <= {1'b0, PERIOD};
        period_err   <= 1'b0;
        valid        <= 1'b1;
        stuck_hi     <= 1'b1;
      end
      if (to_lo) begin
        duty_count   <= '0;
        period_count <= {1'b0, PERIOD};
        period_err   <= 1'b0;
        valid        <= 1'b1;
        stuck_lo     <= 1'b1;
      end
      if (idle_to) begin
        if (hist) stuck_hi <= 1'b1;
        else      stuck_lo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: directed and random PWM waveforms checked
// against a timestamp-based reference of expected publications.
module tb_pwm_duty_capture;

  localparam int TIMEOUT  = 2084;
  localparam int PERIOD   = 1042;
  localparam int DUTY_MAX = 2047;
  localparam int CNT_MAX  = 4095;
  localparam int LAT      = 4;  // drive point to observed valid, in clk edges

  logic        clk;
  logic        rst;
  logic        ampPWM;
  logic        ampSD;
  logic [10:0] duty_count;
  logic [11:0] period_count;
  logic        valid;
  logic        stuck_hi;
  logic        stuck_lo;
  logic        period_err;

  pwm_duty_capture #(.WIDTH(11), .PERIOD(11'd1042), .TIMEOUT(2084)) dut (
    .clk(clk), .rst(rst), .ampPWM(ampPWM), .ampSD(ampSD),
    .duty_count(duty_count), .period_count(period_count), .valid(valid),
    .stuck_hi(stuck_hi), .stuck_lo(stuck_lo), .period_err(period_err)
  );

  typedef struct {
    int t;
    int duty;
    int period;
    int err;
  } exp_t;

  exp_t q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   now       = 0;
  bit   cur       = 0;
  // Reference: an open period started at t_rise; m_low once its fall is seen.
  bit   m_open    = 0;
  bit   m_low     = 0;
  int   t_rise    = 0;
  int   t_fall    = 0;
  int   held_duty   = 0;
  int   held_period = 0;
  int   held_err    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic push(input int t, input int d, input int p, input int e);
    exp_t x;
    x.t = t; x.duty = d; x.period = p; x.err = e;
    q.push_back(x);
  endtask

  // Advance to the next falling clock edge and check any valid pulse.
  task automatic tick();
    bit   exp_v;
    exp_t e;
    @(negedge clk);
    now++;
    exp_v = (q.size() > 0) && (q[0].t == now);
    if (exp_v || valid) begin
      chk("valid", {31'd0, valid}, {31'd0, exp_v});
      if (exp_v) begin
        e = q.pop_front();
        $display("t=%0d valid=%0d duty=%0d/%0d period=%0d/%0d err=%0d/%0d",
                 now, valid, duty_count, e.duty, period_count, e.period, period_err, e.err);
        if (valid) begin
          chk("duty_count", {21'd0, duty_count}, e.duty);
          chk("period_count", {20'd0, period_count}, e.period);
          chk("period_err", {31'd0, period_err}, e.err);
        end
        held_duty = e.duty; held_period = e.period; held_err = e.err;
      end else begin
        $display("t=%0d unexpected valid duty=%0d period=%0d", now, duty_count, period_count);
      end
    end
  endtask

  // Reference rules for an edge driven at time now, with the new level
  // then held for n cycles before the next opposite edge.
  task automatic model_edge(input bit v, input int n);
    if (v) begin
      if (m_open && m_low)
        push(now + LAT, imin(t_fall - t_rise, DUTY_MAX), imin(now - t_rise, CNT_MAX),
             ((now - t_rise) != PERIOD) ? 1 : 0);
      m_open = 1; m_low = 0; t_rise = now;
      if (n > TIMEOUT) begin
        push(now + LAT + TIMEOUT, PERIOD, PERIOD, 0);
        m_open = 0;
      end
    end else if (m_open) begin
      m_low = 1; t_fall = now;
      if (n > TIMEOUT) begin
        push(now + LAT + TIMEOUT, 0, PERIOD, 0);
        m_open = 0;
      end
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0 && v != cur) model_edge(v, n);
      ampPWM = v;
    end
    cur = v;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, valid}, 0);
    chk({tag, "_duty"}, {21'd0, duty_count}, 0);
    chk({tag, "_period"}, {20'd0, period_count}, 0);
    chk({tag, "_stuck_hi"}, {31'd0, stuck_hi}, 0);
    chk({tag, "_stuck_lo"}, {31'd0, stuck_lo}, 0);
    chk({tag, "_period_err"}, {31'd0, period_err}, 0);
  endtask

  initial begin
    rst = 1'b0; ampSD = 1'b1; ampPWM = 1'b0;

    // Reset state
    wait_cycles(3);
    check_zero("reset");
    rst = 1'b1;

    // Idle low past the timeout: stuck_lo without a valid
    hold(0, 2200);
    chk("idle_stuck_lo", {31'd0, stuck_lo}, 1);
    chk("idle_stuck_hi", {31'd0, stuck_hi}, 0);

    // Square wave 521/521; the first rise clears stuck_lo
    hold(1, 521);
    chk("rise_clears_stuck_lo", {31'd0, stuck_lo}, 0);
    hold(0, 521);
    for (int i = 0; i < 3; i++) begin
      hold(1, 521);
      hold(0, 521);
    end

    // Off-nominal period 1000, high 400
    for (int i = 0; i < 3; i++) begin
      hold(1, 400);
      hold(0, 600);
    end

    // Duty steps 1 and 1041, then constant low into a LOW timeout
    hold(1, 1);
    hold(0, 1041);
    hold(1, 1041);
    hold(0, 1);
    hold(1, 521);
    hold(0, 2300);
    chk("low_timeout_stuck_lo", {31'd0, stuck_lo}, 1);

    // Random periods
    for (int i = 0; i < 8; i++) begin
      hold(1, $urandom_range(1, 1200));
      hold(0, $urandom_range(1, 1200));
    end

    // Edge exactly at timeout wins; duty and period saturate
    hold(1, TIMEOUT);
    hold(0, TIMEOUT);
    hold(1, 100);
    chk("edge_wins_stuck_hi", {31'd0, stuck_hi}, 0);
    chk("edge_wins_stuck_lo", {31'd0, stuck_lo}, 0);

    // Held high for 3000 cycles
    hold(0, 300);
    hold(1, 3000);
    chk("held_high_stuck_hi", {31'd0, stuck_hi}, 1);
    hold(0, 10);
    chk("fall_clears_stuck_hi", {31'd0, stuck_hi}, 0);

    // ampSD dropped mid-HIGH for 10 cycles
    hold(1, 300);
    ampSD = 1'b0;
    m_open = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sd_hold_duty", {21'd0, duty_count}, held_duty);
      chk("sd_hold_period", {20'd0, period_count}, held_period);
      chk("sd_hold_err", {31'd0, period_err}, held_err);
      chk("sd_stuck_hi", {31'd0, stuck_hi}, 0);
      chk("sd_stuck_lo", {31'd0, stuck_lo}, 0);
    end
    ampSD = 1'b1;
    wait_cycles(200);
    hold(0, 400);
    hold(1, 600);
    hold(0, 400);
    hold(1, 50);

    // Reset pulsed mid-LOW: outputs clear at once, two rises before next valid
    hold(0, 150);
    #2 rst = 1'b0;
    #1 check_zero("async_reset");
    m_open = 0;
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(150);
    hold(1, 300);
    hold(0, 500);
    hold(1, 300);
    hold(0, 200);

    wait_cycles(10);
    chk("pending_valids", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
